// File: rtl/ddr_word_assembler.sv
// Re-serialises DDR lane pairs into time-ordered beats and packs NPAIRS pairs
// per word, with edge/pair slip alignment and a 2-entry valid/ready buffer.
module ddr_word_assembler #(
    parameter int WIDTH  = 8,
    parameter int NPAIRS = 2,
    localparam int OUT_W = 2 * WIDTH * NPAIRS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din_h,
    input  logic [WIDTH-1:0] din_l,
    input  logic             edge_slip,
    input  logic             pair_slip,
    input  logic             clear,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             overflow
);

    localparam int CW = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPAIRS - 1);

    logic [CW-1:0]    cnt_q, cnt_n;
    logic             slip_q, slip_n;
    logic [WIDTH-1:0] prev_q, prev_n;
    logic             pvld_q, pvld_n;
    logic             es_q;
    logic [OUT_W-1:0] word_q, word_n;
    logic [WIDTH-1:0] first, second;
    logic             push;

    logic [OUT_W-1:0] q0, q1;
    logic [1:0]       fcnt;
    logic             pop, drop;

    always_comb begin
        cnt_n  = (edge_slip != es_q) ? '0 : cnt_q;
        pvld_n = (edge_slip != es_q) ? 1'b0 : pvld_q;
        prev_n = prev_q;
        slip_n = slip_q | pair_slip;
        word_n = word_q;
        push   = 1'b0;
        first  = edge_slip ? prev_q : din_h;
        second = edge_slip ? din_h : din_l;
        if (in_valid) begin
            prev_n = din_l;
            // Priming pair in slip mode also eats any pending pair slip
            if (edge_slip && !pvld_n) begin
                slip_n = 1'b0;
            end else if (slip_n) begin
                slip_n = 1'b0;
            end else begin
                for (int i = 0; i < NPAIRS; i++) begin
                    if (cnt_n == CW'(i))
                        word_n[i*2*WIDTH +: 2*WIDTH] = {second, first};
                end
                if (cnt_n == LAST) begin
                    push  = 1'b1;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt_n + 1'b1;
                end
            end
            pvld_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            slip_q <= 1'b0;
            prev_q <= '0;
            pvld_q <= 1'b0;
            es_q   <= 1'b0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_n;
            slip_q <= slip_n;
            prev_q <= prev_n;
            pvld_q <= pvld_n;
            es_q   <= edge_slip;
            word_q <= word_n;
        end
    end

    assign m_valid = (fcnt != 2'd0);
    assign m_data  = q0;
    assign pop     = m_valid && m_ready;
    assign drop    = push && (fcnt == 2'd2) && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0       <= '0;
            q1       <= '0;
            fcnt     <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (push && !drop) begin
                if (pop) begin
                    if (fcnt == 2'd2) begin
                        q0 <= q1;
                        q1 <= word_n;
                    end else begin
                        q0 <= word_n;
                    end
                end else begin
                    if (fcnt == 2'd0)
                        q0 <= word_n;
                    else
                        q1 <= word_n;
                    fcnt <= fcnt + 2'd1;
                end
            end else if (pop) begin
                q0   <= q1;
                fcnt <= fcnt - 2'd1;
            end
            if (drop)
                overflow <= 1'b1;
            else if (clear)
                overflow <= 1'b0;
        end
    end

endmodule
